// File: rtl/auto_opponent_pkg.sv
// auto_opponent_pkg
// Shared definitions for the tug-of-war auto opponent.
// This package provides:
//   - the opponent state encoding (opp_state_t);
//   - the default widths and the press length;
//   - a helper that sizes the press-hold counter.
package auto_opponent_pkg;

  localparam int REACT_W_DEF      = 8;
  localparam int JIT_W_DEF        = 4;
  localparam int PRESS_CYCLES_DEF = 8;
  localparam int CNT_W_DEF        = 9;
  localparam int COUNT_W          = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DELAY    = 2'd1,
    PRESS    = 2'd2,
    WAIT_CLR = 2'd3
  } opp_state_t;

  // Width of a down-counter that must hold values 0 .. cycles-1.
  function automatic int hold_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/auto_opponent_if.sv
// auto_opponent_if
// Bundles the signals exchanged between the game side and the opponent.
//
// Signals driven by the game side (master):
//   enable, slowen, rand_bit, leds_on, clear, reaction
//
// Signals driven by the opponent (slave):
//   pb_out, fired, press_count
//
// rand_bit carries the serial LFSR bit. The name avoids the reserved word "rand".
interface auto_opponent_if
  import auto_opponent_pkg::*;
#(
  parameter int REACT_W = REACT_W_DEF
);

  logic               enable;
  logic               slowen;
  logic               rand_bit;
  logic               leds_on;
  logic               clear;
  logic [REACT_W-1:0] reaction;
  logic               pb_out;
  logic               fired;
  logic [COUNT_W-1:0] press_count;

  modport master (
    output enable, slowen, rand_bit, leds_on, clear, reaction,
    input  pb_out, fired, press_count
  );

  modport slave (
    input  enable, slowen, rand_bit, leds_on, clear, reaction,
    output pb_out, fired, press_count
  );

endinterface

// File: rtl/auto_opponent_jitter.sv
// opp_jitter
// JIT_W-bit shift register with serial input and parallel output.
// It shifts rand_bit in at the LSB on every clk cycle.
// The parallel value supplies the random part of the reaction delay.
// JIT_W must be at least 2.
//
// Ports:
//   clk, rst  - clock; async active-high reset (clears the register)
//   rand_bit  - serial pseudo-random input
//   jitter    - current register contents
module opp_jitter #(
  parameter int JIT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rand_bit,
  output logic [JIT_W-1:0] jitter
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) jitter <= '0;
    else     jitter <= {jitter[JIT_W-2:0], rand_bit};
  end

endmodule

// File: rtl/auto_opponent.sv
// auto_opponent
// Computer-controlled second player for the tug-of-war game.
// When a round starts (a rising edge on leds_on), it waits (reaction + jitter + 1)
// slowen ticks. It then holds pb_out high for PRESS_CYCLES clk cycles.
//
// Ports:
//   clk, rst  - system clock; async active-high reset
//   bus       - auto_opponent_if.slave, carrying:
//                 inputs:  enable, slowen, rand_bit, leds_on, clear, reaction
//                 outputs: pb_out (registered), fired (one-cycle pulse when pb_out rises),
//                          press_count (saturating count of presses)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a leds_on rise while enabled
// DELAY    | counting slowen ticks down from reaction + jitter
// PRESS    | pb_out held high for PRESS_CYCLES clk cycles
// WAIT_CLR | press done; waiting for the controller's clear
module auto_opponent
  import auto_opponent_pkg::*;
#(
  parameter int REACT_W      = REACT_W_DEF,
  parameter int JIT_W        = JIT_W_DEF,
  parameter int PRESS_CYCLES = PRESS_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  auto_opponent_if.slave   bus
);

  localparam int               HOLD_W    = hold_width(PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(PRESS_CYCLES - 1);

  opp_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               pb_q, pb_d;
  logic               fired_q, fired_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               leds_on_d;
  logic [JIT_W-1:0]   jitter;
  logic               rise;

  opp_jitter #(.JIT_W(JIT_W)) u_jitter (
    .clk      (clk),
    .rst      (rst),
    .rand_bit (bus.rand_bit),
    .jitter   (jitter)
  );

  assign rise = bus.leds_on & ~leds_on_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      pb_q      <= 1'b0;
      fired_q   <= 1'b0;
      count_q   <= '0;
      leds_on_d <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      pb_q      <= pb_d;
      fired_q   <= fired_d;
      count_q   <= count_d;
      leds_on_d <= bus.leds_on;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    pb_d    = pb_q;
    fired_d = 1'b0;
    count_d = count_q;

    if (!bus.enable) begin
      state_d = IDLE;
      pb_d    = 1'b0;
    end else if (bus.clear && (state_q == DELAY || state_q == PRESS)) begin
      // The human already ended the round; any press in progress is cut short.
      state_d = IDLE;
      pb_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pb_d = 1'b0;
          // A rise always wins over a coincident slowen tick; that tick is not counted.
          if (rise) begin
            cnt_d   = CNT_W'(bus.reaction) + CNT_W'(jitter);
            state_d = DELAY;
          end
        end
        DELAY: begin
          if (bus.slowen) begin
            if (cnt_q == '0) begin
              state_d = PRESS;
              pb_d    = 1'b1;
              fired_d = 1'b1;
              hold_d  = HOLD_LOAD;
              if (count_q != '1) count_d = count_q + COUNT_W'(1);
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        PRESS: begin
          if (hold_q == '0) begin
            pb_d    = 1'b0;
            state_d = WAIT_CLR;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
        WAIT_CLR: begin
          pb_d = 1'b0;
          if (bus.clear) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.pb_out      = pb_q;
  assign bus.fired       = fired_q;
  assign bus.press_count = count_q;

endmodule

// File: tb/tb_auto_opponent.sv
module tb_auto_opponent;
  import auto_opponent_pkg::*;

  localparam int JIT_W        = JIT_W_DEF;
  localparam int PRESS_CYCLES = PRESS_CYCLES_DEF;

  typedef struct {
    int ticks;   // slowen ticks after the rise on which the press must appear
    int count;   // press_count expected on the fired cycle
    int width;   // clk cycles pb_out must stay high
  } exp_t;

  logic clk;
  logic rst;
  auto_opponent_if bus ();

  auto_opponent dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   hist[$];          // last JIT_W rand bits sampled, oldest first
  int   rand_mode = 0;    // 0: hold 0, 1: hold 1, 2: random
  int   model_count = 0;

  int   ticks = 0;
  bit   leds_prev = 0;
  bit   in_press = 0;
  int   width = 0;
  int   exp_width = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_jit();
    int j = 0;
    foreach (hist[i]) j = (j << 1) | int'(hist[i]);
    return j;
  endfunction

  task automatic reset_hist();
    hist.delete();
    repeat (JIT_W) hist.push_back(1'b0);
  endtask

  // Drives one cycle of inputs at a negedge.
  // It then waits for the following negedge.
  task automatic step(input bit s, input bit c);
    bit b;
    bus.slowen = s;
    bus.clear  = c;
    if (rand_mode == 0)      b = 1'b0;
    else if (rand_mode == 1) b = 1'b1;
    else                     b = 1'($urandom_range(0, 1));
    bus.rand_bit = b;
    hist.push_back(b);
    if (hist.size() > JIT_W) void'(hist.pop_front());
    @(negedge clk);
  endtask

  // One game round. abort_at and drop_at give the tick count, counted from the rise,
  // at which clear or enable=0 is applied (-1 means never).
  // If trunc is nonzero, clear is applied this many cycles into the press.
  task automatic round(input int react, input int mode, input int gap_max, input bit en,
                       input bit same_edge, input int abort_at, input int drop_at,
                       input int trunc);
    int   jit;
    int   need;
    bit   fires;
    exp_t e;
    rand_mode    = mode;
    bus.reaction = 8'(react);
    bus.enable   = en;
    bus.leds_on  = 1'b0;
    repeat (JIT_W + $urandom_range(0, 2)) step(0, 0);
    bus.leds_on = 1'b1;
    jit   = model_jit();
    need  = react + jit + 1;
    fires = en && (abort_at < 0) && (drop_at < 0);
    if (fires) begin
      model_count = (model_count < 255) ? model_count + 1 : 255;
      e.ticks = need;
      e.count = model_count;
      e.width = (trunc > 0) ? trunc : PRESS_CYCLES;
      exp_q.push_back(e);
    end
    step(same_edge, 0);
    if (!en) bus.enable = 1'b1;
    for (int t = 0; t < need; t++) begin
      repeat ($urandom_range(0, gap_max)) step(0, 0);
      if (t == abort_at) begin
        step(0, 1);
        break;
      end
      if (t == drop_at) begin
        bus.enable = 1'b0;
        step(0, 0);
        bus.enable = 1'b1;
        break;
      end
      step(1, 0);
    end
    if (fires) begin
      if (trunc > 0) begin
        repeat (trunc - 1) step(0, 0);
        step(0, 1);
      end else begin
        repeat (PRESS_CYCLES + 2) step(0, 0);
      end
    end else begin
      // leds_on is still high, so these ticks must not produce a press.
      repeat (need + 3) step(1, 0);
    end
    bus.leds_on = 1'b0;
    step(0, 1);
    step(0, 0);
  endtask

  // Tracks the slowen ticks seen since the last leds_on rise.
  always @(posedge clk) begin
    if (rst) begin
      ticks     = 0;
      leds_prev = 1'b0;
    end else begin
      if (bus.leds_on && !leds_prev) ticks = 0;
      else if (bus.slowen)           ticks++;
      leds_prev = bus.leds_on;
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      in_press = 1'b0;
    end else begin
      if (bus.fired) begin
        chk("fired_with_pb_out", int'(bus.pb_out), 1);
        chk("fired_single_cycle", int'(in_press), 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_press: fired=1 at tick %0d, required no press", ticks);
        end else begin
          e = exp_q.pop_front();
          chk("press_tick", ticks, e.ticks);
          chk("press_count", int'(bus.press_count), e.count);
          exp_width = e.width;
          width     = 0;
          in_press  = 1'b1;
        end
      end
      if (in_press) begin
        if (bus.pb_out) width++;
        else begin
          chk("press_width", width, exp_width);
          in_press = 1'b0;
        end
      end else begin
        chk("pb_out_idle", int'(bus.pb_out), 0);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    clk          = 1'b0;
    rst          = 1'b1;
    bus.enable   = 1'b0;
    bus.slowen   = 1'b0;
    bus.rand_bit = 1'b0;
    bus.leds_on  = 1'b0;
    bus.clear    = 1'b0;
    bus.reaction = '0;
    reset_hist();
    repeat (2) @(negedge clk);
    chk("reset_pb_out", int'(bus.pb_out), 0);
    chk("reset_fired", int'(bus.fired), 0);
    chk("reset_press_count", int'(bus.press_count), 0);
    rst = 1'b0;

    // Basic press: reaction 3, jitter 0.
    round(3, 0, 2, 1, 0, -1, -1, 0);
    // Jitter add: jitter 15 plus reaction 2 gives a press on the 18th tick.
    round(2, 1, 1, 1, 0, -1, -1, 0);
    // Clear after 5 ticks aborts the round.
    round(10, 0, 1, 1, 0, 5, -1, 0);
    // Clear 3 cycles into the press truncates it.
    round(4, 2, 1, 1, 0, -1, -1, 3);
    // Enable is low during the rise.
    round(5, 2, 1, 0, 0, -1, -1, 0);
    // Enable drops mid-delay.
    round(6, 2, 1, 1, 0, -1, 3, 0);
    // slowen coincides with the rise.
    round(0, 0, 2, 1, 1, -1, -1, 0);
    // Randomized rounds.
    repeat (20) round($urandom_range(0, 40), 2, 3, 1, 1'($urandom_range(0, 1)), -1, -1, 0);
    // Maximum delay.
    round(255, 1, 0, 1, 0, -1, -1, 0);

    // Async reset during a press.
    bus.reaction = 8'd2;
    bus.enable   = 1'b1;
    rand_mode    = 0;
    bus.leds_on  = 1'b0;
    repeat (JIT_W + 1) step(0, 0);
    bus.leds_on = 1'b1;
    model_count = (model_count < 255) ? model_count + 1 : 255;
    e.ticks = 3;
    e.count = model_count;
    e.width = PRESS_CYCLES;
    exp_q.push_back(e);
    step(0, 0);
    repeat (3) step(1, 0);
    repeat (2) step(0, 0);
    #2;
    rst         = 1'b1;
    bus.leds_on = 1'b0;
    #1;
    chk("async_rst_pb_out", int'(bus.pb_out), 0);
    chk("async_rst_press_count", int'(bus.press_count), 0);
    chk("async_rst_fired", int'(bus.fired), 0);
    exp_q.delete();
    model_count = 0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    reset_hist();
    @(negedge clk);
    repeat (8) step(1, 0);
    round(1, 2, 1, 1, 0, -1, -1, 0);

    // Saturation with zero delay.
    repeat (260) round(0, 0, 0, 1, 0, -1, -1, 0);

    repeat (4) step(0, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("final_press_count", int'(bus.press_count), 255);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
